// File: rtl/timer_display_driver.sv
// Countdown-timer display driver: sequential binary-to-BCD conversion feeding a
// 4-digit multiplexed common-anode seven-segment display with blanking and blink.
module timer_display_driver #(
    parameter int unsigned TIMER_BITS = 6,
    parameter int unsigned SCAN_DIV   = 100000,
    parameter int unsigned BLINK_DIV  = 50000000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [TIMER_BITS-1:0] value_in,
    input  logic                  done_in,
    input  logic                  blank_en,
    output logic [3:0]            an,
    output logic [6:0]            seg,
    output logic [15:0]           bcd_out,
    output logic                  bcd_valid
);

    localparam int unsigned SCAN_W  = (SCAN_DIV > 1)  ? $clog2(SCAN_DIV)  : 1;
    localparam int unsigned BLINK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam int unsigned CNT_W   = $clog2(TIMER_BITS + 1);
    localparam int unsigned CAT_W   = 16 + TIMER_BITS;

    localparam logic [SCAN_W-1:0]  SCAN_LAST  = SCAN_W'(SCAN_DIV - 1);
    localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_DIV - 1);
    localparam logic [CNT_W-1:0]   CNT_LOAD   = CNT_W'(TIMER_BITS);
    localparam logic [6:0]         SEG_OFF    = 7'h7F;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t                state, state_next;
    logic [TIMER_BITS-1:0] shift_reg, shift_next;
    logic [TIMER_BITS-1:0] last_value, last_next;
    logic [15:0]           scratch, scratch_next;
    logic [15:0]           bcd_next;
    logic [CNT_W-1:0]      bit_cnt, bit_cnt_next;
    logic                  bcd_valid_next;
    logic [15:0]           adjusted;
    logic [CAT_W-1:0]      shifted;

    logic [SCAN_W-1:0]     scan_cnt;
    logic [1:0]            digit_sel;
    logic [BLINK_W-1:0]    blink_cnt;
    logic                  blink_phase;

    logic [3:0]            disp_an;
    logic [6:0]            disp_seg;
    logic [3:0]            digit_val;
    logic                  lead_zero;

    function automatic logic [6:0] seg_code(input logic [3:0] d);
        logic [6:0] code;
        code = SEG_OFF;
        case (d)
            4'd0: code = 7'h40;
            4'd1: code = 7'h79;
            4'd2: code = 7'h24;
            4'd3: code = 7'h30;
            4'd4: code = 7'h19;
            4'd5: code = 7'h12;
            4'd6: code = 7'h02;
            4'd7: code = 7'h78;
            4'd8: code = 7'h00;
            4'd9: code = 7'h10;
            default: code = SEG_OFF;
        endcase
        return code;
    endfunction

    // Conversion FSM and datapath registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            shift_reg  <= '0;
            last_value <= '0;
            scratch    <= '0;
            bit_cnt    <= '0;
            bcd_out    <= '0;
            bcd_valid  <= 1'b0;
        end else begin
            state      <= state_next;
            shift_reg  <= shift_next;
            last_value <= last_next;
            scratch    <= scratch_next;
            bit_cnt    <= bit_cnt_next;
            bcd_out    <= bcd_next;
            bcd_valid  <= bcd_valid_next;
        end
    end

    // Double-dabble: value changes are only sampled in IDLE, so bcd_out never shows a partial result
    always_comb begin
        state_next     = state;
        shift_next     = shift_reg;
        last_next      = last_value;
        scratch_next   = scratch;
        bit_cnt_next   = bit_cnt;
        bcd_next       = bcd_out;
        bcd_valid_next = 1'b0;
        adjusted       = scratch;
        for (int i = 0; i < 4; i++) begin
            if (scratch[4*i +: 4] >= 4'd5) begin
                adjusted[4*i +: 4] = scratch[4*i +: 4] + 4'd3;
            end
        end
        shifted = {adjusted, shift_reg} << 1;

        case (state)
            IDLE: begin
                if (value_in != last_value) begin
                    shift_next   = value_in;
                    last_next    = value_in;
                    scratch_next = '0;
                    bit_cnt_next = CNT_LOAD;
                    state_next   = SHIFT;
                end
            end
            SHIFT: begin
                scratch_next = shifted[TIMER_BITS +: 16];
                shift_next   = shifted[TIMER_BITS-1:0];
                bit_cnt_next = bit_cnt - CNT_W'(1);
                if (bit_cnt == CNT_W'(1)) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                bcd_next       = scratch;
                bcd_valid_next = 1'b1;
                state_next     = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Digit scan timebase
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            scan_cnt  <= '0;
            digit_sel <= 2'd0;
        end else if (scan_cnt == SCAN_LAST) begin
            scan_cnt  <= '0;
            digit_sel <= digit_sel + 2'd1;
        end else begin
            scan_cnt  <= scan_cnt + SCAN_W'(1);
        end
    end

    // Blink timebase: phase restarts visible whenever done_in is low
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            blink_cnt   <= '0;
            blink_phase <= 1'b1;
        end else if (!done_in) begin
            blink_cnt   <= '0;
            blink_phase <= 1'b1;
        end else if (blink_cnt == BLINK_LAST) begin
            blink_cnt   <= '0;
            blink_phase <= ~blink_phase;
        end else begin
            blink_cnt   <= blink_cnt + BLINK_W'(1);
        end
    end

    // Gating blink with done_in lets the display recover on the very next update after done_in drops
    always_comb begin
        digit_val = bcd_out[{digit_sel, 2'b00} +: 4];
        lead_zero = (digit_sel != 2'd0) && ((bcd_out >> {digit_sel, 2'b00}) == 16'd0);
        disp_an   = 4'b1111;
        disp_seg  = SEG_OFF;
        if (blank_en) begin
            disp_an  = 4'b1111;
            disp_seg = SEG_OFF;
        end else if (done_in && !blink_phase) begin
            disp_an  = 4'b1111;
            disp_seg = SEG_OFF;
        end else if (lead_zero) begin
            disp_an  = 4'b1111;
            disp_seg = SEG_OFF;
        end else begin
            disp_an  = ~(4'b0001 << digit_sel);
            disp_seg = seg_code(digit_val);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            an  <= 4'b1111;
            seg <= SEG_OFF;
        end else begin
            an  <= disp_an;
            seg <= disp_seg;
        end
    end

endmodule

// File: tb/tb_timer_display_driver.sv
// Randomised and directed bench for timer_display_driver, checked cycle by cycle
// against a behavioural model of conversion latency, scan, blink and blanking.
module tb_timer_display_driver;

    localparam int unsigned TB_BITS  = 6;
    localparam int unsigned TB_SCAN  = 4;
    localparam int unsigned TB_BLINK = 8;

    logic        clk;
    logic        reset;
    logic [5:0]  value_in;
    logic        done_in;
    logic        blank_en;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic [15:0] bcd_out;
    logic        bcd_valid;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    // Reference model state
    int m_last, m_busy, m_bcd, m_valid, m_scan, m_sel, m_blink, m_phase, m_an, m_seg;
    logic [6:0] seg_tab [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

    timer_display_driver #(
        .TIMER_BITS(TB_BITS),
        .SCAN_DIV  (TB_SCAN),
        .BLINK_DIV (TB_BLINK)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .value_in (value_in),
        .done_in  (done_in),
        .blank_en (blank_en),
        .an       (an),
        .seg      (seg),
        .bcd_out  (bcd_out),
        .bcd_valid(bcd_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int to_bcd(input int v);
        return ((v / 1000) % 10) * 4096 + ((v / 100) % 10) * 256 + ((v / 10) % 10) * 16 + (v % 10);
    endfunction

    task automatic model_reset();
        m_last = 0; m_busy = 0; m_bcd = 0; m_valid = 0;
        m_scan = 0; m_sel = 0; m_blink = 0; m_phase = 1;
        m_an = 'hF; m_seg = 'h7F;
    endtask

    // One clock edge of the model, display computed from pre-edge state
    task automatic model_step();
        int upper;
        upper = m_bcd >> (4 * m_sel);
        if (blank_en || (done_in && m_phase == 0) || (m_sel > 0 && upper == 0)) begin
            m_an  = 'hF;
            m_seg = 'h7F;
        end else begin
            m_an  = 'hF ^ (1 << m_sel);
            m_seg = int'(seg_tab[upper % 16]);
        end

        m_valid = 0;
        if (m_busy > 0) begin
            m_busy--;
            if (m_busy == 0) begin
                m_bcd   = to_bcd(m_last);
                m_valid = 1;
            end
        end else if (int'(value_in) != m_last) begin
            m_last = int'(value_in);
            m_busy = TB_BITS + 1;
        end

        if (m_scan == TB_SCAN - 1) begin
            m_scan = 0;
            m_sel  = (m_sel + 1) % 4;
        end else begin
            m_scan++;
        end

        if (!done_in) begin
            m_blink = 0;
            m_phase = 1;
        end else if (m_blink == TB_BLINK - 1) begin
            m_blink = 0;
            m_phase = 1 - m_phase;
        end else begin
            m_blink++;
        end
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        check("an",        16'(an),        16'(m_an));
        check("seg",       16'(seg),       16'(m_seg));
        check("bcd_out",   bcd_out,        16'(m_bcd));
        check("bcd_valid", 16'(bcd_valid), 16'(m_valid));
    endtask

    task automatic tick();
        @(posedge clk);
        if (reset) model_step();
        @(negedge clk);
        check_all();
    endtask

    task automatic wait_valid(output int lat);
        int i;
        i   = 0;
        lat = 0;
        while (lat == 0 && i < 40) begin
            i++;
            tick();
            if (bcd_valid === 1'b1) lat = i;
        end
    endtask

    // Counts cycles showing a given digit pattern over one full 16-cycle scan period
    task automatic scan_window(input logic [3:0] an0, input logic [6:0] seg0,
                               output int c0, output int c_dark);
        c0 = 0;
        c_dark = 0;
        for (int i = 0; i < 16; i++) begin
            tick();
            if (an == an0 && seg == seg0) c0++;
            if (an == 4'b1111 && seg == 7'h7F) c_dark++;
        end
    endtask

    initial begin
        int lat, c0, c1, c_dark, pulses;

        reset    = 1'b0;
        value_in = 6'd30;
        done_in  = 1'b0;
        blank_en = 1'b0;
        model_reset();

        // Reset held with a pending value
        repeat (3) begin
            @(negedge clk);
            check_all();
        end
        check("rst_an",  16'(an), 16'h000F);
        check("rst_seg", 16'(seg), 16'h007F);
        reset = 1'b1;
        wait_valid(lat);
        check("lat_first", 16'(lat), 16'd8);
        check("bcd_30", bcd_out, 16'h0030);

        // Steady value 30 over one scan period
        scan_window(4'b1110, 7'h40, c0, c_dark);
        check("d0_30_cnt", 16'(c0), 16'd4);
        check("dark_30_cnt", 16'(c_dark), 16'd8);
        c1 = 0;
        for (int i = 0; i < 16; i++) begin
            tick();
            if (an == 4'b1101 && seg == 7'h30) c1++;
        end
        check("d1_30_cnt", 16'(c1), 16'd4);

        // Leading-zero blanking
        value_in = 6'd9;
        wait_valid(lat);
        check("bcd_9", bcd_out, 16'h0009);
        scan_window(4'b1110, 7'h10, c0, c_dark);
        check("d0_9_cnt", 16'(c0), 16'd4);
        check("dark_9_cnt", 16'(c_dark), 16'd12);
        value_in = 6'd0;
        wait_valid(lat);
        check("bcd_0", bcd_out, 16'h0000);
        scan_window(4'b1110, 7'h40, c0, c_dark);
        check("d0_0_cnt", 16'(c0), 16'd4);
        check("dark_0_cnt", 16'(c_dark), 16'd12);

        // Value change three cycles into SHIFT is deferred, not lost
        value_in = 6'd30;
        repeat (4) tick();
        value_in = 6'd29;
        wait_valid(lat);
        check("bcd_first_30", bcd_out, 16'h0030);
        wait_valid(lat);
        check("lat_second", 16'(lat), 16'd8);
        check("bcd_second_29", bcd_out, 16'h0029);

        // Blink with value 0, then drop done_in while dark
        value_in = 6'd0;
        wait_valid(lat);
        done_in = 1'b1;
        repeat (40) tick();
        lat = 0;
        while (m_phase != 0 && lat < 40) begin
            lat++;
            tick();
        end
        tick();
        check("blink_dark_an", 16'(an), 16'h000F);
        done_in = 1'b0;
        repeat (20) tick();

        // blank_en pulse mid-scan
        value_in = 6'd42;
        wait_valid(lat);
        repeat (5) tick();
        blank_en = 1'b1;
        tick();
        repeat (3) begin
            tick();
            check("blank_an", 16'(an), 16'h000F);
        end
        blank_en = 1'b0;
        repeat (20) tick();

        // Randomised traffic
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 7) == 0) value_in = 6'($urandom_range(0, 63));
            if ($urandom_range(0, 19) == 0) done_in = ~done_in;
            if ($urandom_range(0, 15) == 0) blank_en = ~blank_en;
            tick();
        end

        // Asynchronous reset mid-SHIFT
        done_in  = 1'b0;
        blank_en = 1'b0;
        value_in = 6'd17;
        repeat (12) tick();
        value_in = 6'd45;
        repeat (3) tick();
        #2 reset = 1'b0;
        #1;
        check("async_an",    16'(an), 16'h000F);
        check("async_seg",   16'(seg), 16'h007F);
        check("async_bcd",   bcd_out, 16'h0000);
        check("async_valid", 16'(bcd_valid), 16'h0000);
        model_reset();
        value_in = 6'd0;
        repeat (2) tick();
        reset = 1'b1;
        pulses = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (bcd_valid === 1'b1) pulses++;
        end
        check("aborted_pulses", 16'(pulses), 16'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
